pipe_hazard_ctrl: RTL

- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Owns the hold and bubble controls of every inter-stage register: PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Arbitrates four sources:
  - load-use stall requests from ID;
  - multi-cycle EX operations (mul/div);
  - data-memory wait handshakes in MEM, with timeout;
  - taken branches resolved in EX.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/pipe_mem_wait.sv | 57 +++++
 rtl/pipe_hazard_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared stage indices and FSM encodings for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

   localparam int unsigned NUM_STG   = 5;
   localparam int unsigned STG_PC    = 0;
   localparam int unsigned STG_IFID  = 1;
   localparam int unsigned STG_IDEX  = 2;
   localparam int unsigned STG_EXMEM = 3;
   localparam int unsigned STG_MEMWB = 4;

   localparam logic E_RUN  = 1'b0;
   localparam logic E_BUSY = 1'b1;

   localparam logic M_IDLE = 1'b0;
   localparam logic M_WAIT = 1'b1;

endpackage

// File: rtl/pipe_mem_wait.sv
// Data-memory wait sequencer: stalls while an access is outstanding, abandons it after MEM_TIMEOUT cycles.
module pipe_mem_wait
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned TO_W        = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic mem_req,
   input  logic mem_ack,
   output logic mem_stall,
   output logic mem_timeout
);

   logic            state_q, state_d;
   logic [TO_W-1:0] tcnt_q, tcnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= M_IDLE;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      tcnt_d      = tcnt_q;
      mem_stall   = 1'b0;
      mem_timeout = 1'b0;
      case (state_q)
         M_IDLE: begin
            if (mem_req && !mem_ack) begin
               mem_stall = 1'b1;
               tcnt_d    = TO_W'(1);
               state_d   = M_WAIT;
            end
         end
         M_WAIT: begin
            if (mem_ack || !mem_req) begin
               state_d = M_IDLE;
            end else if ((MEM_TIMEOUT != 0) && (tcnt_q == TO_W'(MEM_TIMEOUT))) begin
               mem_timeout = 1'b1;
               state_d     = M_IDLE;
            end else begin
               mem_stall = 1'b1;
               tcnt_d    = tcnt_q + TO_W'(1);
            end
         end
         default: state_d = M_IDLE;
      endcase
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: arbitrates memory waits,
// multi-cycle EX ops, taken branches and load-use stalls into per-register hold/bubble controls.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MC_CNT_W    = 6,
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned TO_W        = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                id_stallreq,
   input  logic                ex_mc_op,
   input  logic [MC_CNT_W-1:0] ex_mc_cycles,
   input  logic                ex_branch_taken,
   input  logic [31:0]         ex_branch_target,
   input  logic                mem_req,
   input  logic                mem_ack,
   output logic [4:0]          stall,
   output logic [4:0]          flush,
   output logic                pc_redirect,
   output logic [31:0]         pc_target,
   output logic                ex_busy,
   output logic                mem_timeout
);

   logic mem_stall, mem_tout;

   pipe_mem_wait #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .TO_W        (TO_W)
   ) u_mem_wait (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem_req     (mem_req),
      .mem_ack     (mem_ack),
      .mem_stall   (mem_stall),
      .mem_timeout (mem_tout)
   );

   logic                e_state_q, e_state_d;
   logic [MC_CNT_W-1:0] cnt_q, cnt_d;
   logic                mc_done_q, mc_done_d;
   logic                ex_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_state_q <= E_RUN;
         cnt_q     <= '0;
         mc_done_q <= 1'b0;
      end else begin
         e_state_q <= e_state_d;
         cnt_q     <= cnt_d;
         mc_done_q <= mc_done_d;
      end
   end

   // mc_done blocks a restart until EX/MEM actually captures the op's result
   always_comb begin
      e_state_d = e_state_q;
      cnt_d     = cnt_q;
      mc_done_d = mc_done_q;
      ex_stall  = 1'b0;
      case (e_state_q)
         E_RUN: begin
            if (ex_mc_op && !mc_done_q && (ex_mc_cycles != '0)) begin
               ex_stall = 1'b1;
               if (ex_mc_cycles == MC_CNT_W'(1)) begin
                  mc_done_d = 1'b1;
               end else begin
                  cnt_d     = ex_mc_cycles - MC_CNT_W'(1);
                  e_state_d = E_BUSY;
               end
            end else if (!mem_stall) begin
               mc_done_d = 1'b0;
            end
         end
         E_BUSY: begin
            ex_stall = 1'b1;
            cnt_d    = cnt_q - MC_CNT_W'(1);
            if (cnt_q == MC_CNT_W'(1)) begin
               mc_done_d = 1'b1;
               e_state_d = E_RUN;
            end
         end
         default: e_state_d = E_RUN;
      endcase
   end

   logic [NUM_STG-1:0] stall_c, flush_c;
   logic               redirect_c;

   always_comb begin
      stall_c    = '0;
      flush_c    = '0;
      redirect_c = 1'b0;
      if (mem_stall) begin
         stall_c[STG_EXMEM:STG_PC] = '1;
         flush_c[STG_MEMWB]        = 1'b1;
      end else if (ex_stall) begin
         stall_c[STG_IDEX:STG_PC] = '1;
         flush_c[STG_EXMEM]       = 1'b1;
      end else if (ex_branch_taken) begin
         redirect_c                 = 1'b1;
         flush_c[STG_IDEX:STG_IFID] = '1;
      end else if (id_stallreq) begin
         stall_c[STG_IFID:STG_PC] = '1;
         flush_c[STG_IDEX]        = 1'b1;
      end
   end

   assign stall       = rst_n ? stall_c : '0;
   assign flush       = rst_n ? flush_c : '0;
   assign pc_redirect = rst_n & redirect_c;
   assign mem_timeout = rst_n & mem_tout;
   assign pc_target   = ex_branch_target;
   assign ex_busy     = (e_state_q == E_BUSY);

endmodule
